lcd_timing_driver: RTL and testbench
====================================

// Module: lcd_timing_driver
// PURPOSE
// - Panel-side timing master for the 480x272 RGB LCD. Generates HS/VS/DE and the pixel_xpos/pixel_ypos
//   request coordinates consumed by the waveform renderer; takes back its registered pixel_data and drives the panel.
// - Sits between the renderer (request/response, fixed 1-cycle response latency) and the LCD connector.
// - All frame and line counters live here; the renderer holds no timing state.
// PARAMETERS
// - H_SYNC   41   HS low width, lcd_clk cycles
// - H_BACK    2   horizontal back porch
// - H_DISP  480   active pixels per line
// - H_FRONT   2   horizontal front porch (H_TOTAL = 525)
// - V_SYNC   10   VS low width, lines
// - V_BACK    2   vertical back porch
// - V_DISP  272   active lines
// - V_FRONT   2   vertical front porch (V_TOTAL = 286)
// PORTS
// - lcd_clk      in   1   pixel clock; sole clock domain
// - sys_rst      in   1   synchronous reset, active-high
// - pixel_data   in  24   renderer colour {R,G,B}; valid 1 cycle after the matching coordinate request
// - pixel_xpos   out 12   requested column, 0..H_DISP-1; 0 when no request
// - pixel_ypos   out 12   requested row, 0..V_DISP-1; 0 when no request
// - lcd_hs       out  1   horizontal sync, active-low
// - lcd_vs       out  1   vertical sync, active-low
// - lcd_de       out  1   data enable, high for the active pixels
// - lcd_rgb      out 24   panel data
// - lcd_bl       out  1   backlight enable
// - frame_start  out  1   1-cycle pulse on the first cycle of each frame (h_cnt=0, v_cnt=0)
// BEHAVIOUR
// - Counters:
//   - h_cnt runs 0..H_TOTAL-1 and wraps to 0.
//   - v_cnt increments only on the h_cnt wrap; it runs 0..V_TOTAL-1 and wraps to 0.
//   - Widths are 12 bit; no counter exceeds its TOTAL-1.
// - Sync signals:
//   - lcd_hs = 0 while h_cnt < H_SYNC.
//   - lcd_vs = 0 while v_cnt < V_SYNC.
//   - Both are registered.
// - Active window: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISP-1] AND v_cnt in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_DISP-1].
//   - lcd_de is registered and high for exactly H_DISP cycles on each of V_DISP lines.
// - Request (one cycle ahead of DE):
//   - data_req is the active window shifted one h_cnt earlier.
//   - When data_req=1: pixel_xpos = h_cnt-(H_SYNC+H_BACK-1), pixel_ypos = v_cnt-(V_SYNC+V_BACK).
//   - When data_req=0: both are 0.
//   - The request covers line-internal cycles only; there is no wrap into the previous line.
// - Response: lcd_rgb = lcd_de ? pixel_data : 24'h0 (combinational mux).
//   - The renderer therefore has exactly 1 cycle of latency: the pixel requested at cycle N appears on the panel at cycle N+1.
// - lcd_bl is forced 0 while sys_rst=1 and set to 1 on the first cycle after reset deasserts.
// - Reset (also mid-frame):
//   - h_cnt=0, v_cnt=0, lcd_hs=1, lcd_vs=1, lcd_de=0, pixel_xpos=0, pixel_ypos=0, frame_start=0, lcd_bl=0.
//   - lcd_rgb is 0 because lcd_de=0.
//   - After release the frame restarts from (0,0), and frame_start pulses on the first post-reset cycle.
// - Boundaries:
//   - The last active pixel is (479,271). The next request is issued only in the following frame.
//   - v_cnt wrap and h_cnt wrap coincide at the frame end; frame_start fires on the wrap cycle.
// CONFIGURATION
// - LCD_TEST_PATTERN_EN defined: pixel_data is ignored and lcd_rgb shows 8 vertical colour bars, 60 px each.
//   - Bar colours, in order: white, yellow, cyan, green, magenta, red, blue, black.
//   - Each colour is selected from the registered column of the active pixel.
//   - Timing and request outputs are unchanged.
// - LCD_TEST_PATTERN_EN undefined: lcd_rgb follows pixel_data as described above; no pattern logic is synthesised.
// STRUCTURE
// - Shared package lcd_pkg holds:
//   - the timing constants (the defaults above plus H_TOTAL and V_TOTAL);
//   - the colour constants COL_WHITE..COL_BLACK, also used by the renderer.
// - Sub-module lcd_bar_pattern, instantiated only under LCD_TEST_PATTERN_EN:
//   - input: 12-bit column; output: 24-bit colour; registered.
//   - lcd_timing_driver compensates that stage's latency so the bars stay aligned with DE.
// TESTING
// - Reset held 5 cycles, then released -> frame_start=1 on the first cycle; hs/vs low; de=0.
//   lcd_bl=1 from the first post-reset cycle onward.
// - Run 1 full frame -> 525*286 = 150150 cycles between frame_start pulses.
//   - 272 lines, each with a 480-cycle DE run.
//   - HS low for 41 cycles per line; VS low for 10 lines (10*525 cycles).
// - Drive pixel_data = {pixel_xpos[7:0], pixel_ypos[7:0], 8'hA5}, registered 1 cycle in the bench
//   -> every DE cycle has lcd_rgb equal to the expected coordinate.
//   - First DE pixel: (0,0). Last DE pixel: (479,271).
// - Check the request window edges -> pixel_xpos=0 exactly 1 cycle before the first lcd_de of a line; pixel_xpos=0 outside.
//   - pixel_xpos=479 on the cycle before DE falls.
// - Assert sys_rst at line 100, pixel 200 for 1 cycle -> outputs return to their reset values on the next edge.
//   - The next frame_start is 1 cycle after release; no partial DE run occurs.
// - With LCD_TEST_PATTERN_EN: line 0 -> lcd_rgb = FFFFFF for pixels 0..59, FFFF00 for 60..119,
//   and so on through 000000 for 420..479.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared timing constants and colour constants for the 480x272 RGB LCD.
package lcd_pkg;

  localparam int unsigned H_SYNC  = 41;
  localparam int unsigned H_BACK  = 2;
  localparam int unsigned H_DISP  = 480;
  localparam int unsigned H_FRONT = 2;
  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;

  localparam int unsigned V_SYNC  = 10;
  localparam int unsigned V_BACK  = 2;
  localparam int unsigned V_DISP  = 272;
  localparam int unsigned V_FRONT = 2;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

  localparam logic [23:0] COL_WHITE   = 24'hFF_FFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFF_FF00;
  localparam logic [23:0] COL_CYAN    = 24'h00_FFFF;
  localparam logic [23:0] COL_GREEN   = 24'h00_FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF_00FF;
  localparam logic [23:0] COL_RED     = 24'hFF_0000;
  localparam logic [23:0] COL_BLUE    = 24'h00_00FF;
  localparam logic [23:0] COL_BLACK   = 24'h00_0000;

  // Eight 60-pixel vertical bars across the active width.
  function automatic logic [23:0] bar_colour(input logic [11:0] col);
    logic [23:0] c;
    if      (col < 12'd60)  c = COL_WHITE;
    else if (col < 12'd120) c = COL_YELLOW;
    else if (col < 12'd180) c = COL_CYAN;
    else if (col < 12'd240) c = COL_GREEN;
    else if (col < 12'd300) c = COL_MAGENTA;
    else if (col < 12'd360) c = COL_RED;
    else if (col < 12'd420) c = COL_BLUE;
    else                    c = COL_BLACK;
    return c;
  endfunction

endpackage

// File: rtl/lcd_timing_driver_if.sv
// Renderer request/response signals and LCD connector pins of the timing driver.
interface lcd_timing_driver_if;
  logic [23:0] pixel_data;
  logic [11:0] pixel_xpos;
  logic [11:0] pixel_ypos;
  logic        lcd_hs;
  logic        lcd_vs;
  logic        lcd_de;
  logic [23:0] lcd_rgb;
  logic        lcd_bl;
  logic        frame_start;

  modport master (
    input  pixel_data,
    output pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, frame_start
  );

  modport slave (
    output pixel_data,
    input  pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, lcd_bl, frame_start
  );
endinterface

// File: rtl/lcd_bar_pattern.sv
// Registered colour-bar generator: maps an active column to one of eight bar colours.
module lcd_bar_pattern
  import lcd_pkg::*;
(
  input  logic        lcd_clk,
  input  logic [11:0] col,
  output logic [23:0] colour
);

  always_ff @(posedge lcd_clk) begin
    colour <= bar_colour(col);
  end

endmodule

// File: rtl/lcd_timing_driver.sv
// Timing master for the 480x272 RGB LCD: HS/VS/DE, pixel requests and panel data.
// Define LCD_TEST_PATTERN_EN to show eight vertical colour bars instead of renderer data.
module lcd_timing_driver
  import lcd_pkg::*;
#(
  parameter int unsigned HSync  = H_SYNC,
  parameter int unsigned HBack  = H_BACK,
  parameter int unsigned HDisp  = H_DISP,
  parameter int unsigned HFront = H_FRONT,
  parameter int unsigned VSync  = V_SYNC,
  parameter int unsigned VBack  = V_BACK,
  parameter int unsigned VDisp  = V_DISP,
  parameter int unsigned VFront = V_FRONT
) (
  input logic                 lcd_clk,
  input logic                 sys_rst,
  lcd_timing_driver_if.master lcd
);

  localparam logic [11:0] HLast     = 12'(HSync + HBack + HDisp + HFront - 1);
  localparam logic [11:0] VLast     = 12'(VSync + VBack + VDisp + VFront - 1);
  localparam logic [11:0] HSyncEnd  = 12'(HSync);
  localparam logic [11:0] VSyncEnd  = 12'(VSync);
  localparam logic [11:0] HActFirst = 12'(HSync + HBack);
  localparam logic [11:0] HActLast  = 12'(HSync + HBack + HDisp - 1);
  localparam logic [11:0] VActFirst = 12'(VSync + VBack);
  localparam logic [11:0] VActLast  = 12'(VSync + VBack + VDisp - 1);
  localparam logic [11:0] HReqFirst = HActFirst - 12'd1;
  localparam logic [11:0] HReqLast  = HActLast - 12'd1;

  // h_cnt_q/v_cnt_q hold the position the registered outputs describe after the next edge.
  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [11:0] xpos_q, xpos_d, ypos_q, ypos_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d, bl_q;
  logic        h_act, h_req, v_act;

  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 12'd1;
    end

    h_act = (h_cnt_q >= HActFirst) && (h_cnt_q <= HActLast);
    h_req = (h_cnt_q >= HReqFirst) && (h_cnt_q <= HReqLast);
    v_act = (v_cnt_q >= VActFirst) && (v_cnt_q <= VActLast);

    hs_d   = (h_cnt_q >= HSyncEnd);
    vs_d   = (v_cnt_q >= VSyncEnd);
    de_d   = h_act && v_act;
    fs_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
    xpos_d = '0;
    ypos_d = '0;
    if (h_req && v_act) begin
      xpos_d = h_cnt_q - HReqFirst;
      ypos_d = v_cnt_q - VActFirst;
    end
  end

  always_ff @(posedge lcd_clk) begin
    if (sys_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      xpos_q  <= '0;
      ypos_q  <= '0;
      bl_q    <= 1'b0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      xpos_q  <= xpos_d;
      ypos_q  <= ypos_d;
      bl_q    <= 1'b1;
    end
  end

  assign lcd.lcd_hs      = hs_q;
  assign lcd.lcd_vs      = vs_q;
  assign lcd.lcd_de      = de_q;
  assign lcd.frame_start = fs_q;
  assign lcd.pixel_xpos  = xpos_q;
  assign lcd.pixel_ypos  = ypos_q;
  assign lcd.lcd_bl      = bl_q;

`ifdef LCD_TEST_PATTERN_EN
  // Feeding the request column gives the bar stage the same 1-cycle lead as the renderer.
  logic [23:0] bar_rgb;

  lcd_bar_pattern u_bar_pattern (
    .lcd_clk (lcd_clk),
    .col     (xpos_q),
    .colour  (bar_rgb)
  );

  assign lcd.lcd_rgb = de_q ? bar_rgb : 24'h0;
`else
  assign lcd.lcd_rgb = de_q ? lcd.pixel_data : 24'h0;
`endif

endmodule

// File: tb/tb_lcd_timing_driver.sv
// Directed bench for lcd_timing_driver: full-size instance plus a reduced-timing instance for frame wrap.
`timescale 1ns/1ps
module tb_lcd_timing_driver;

  logic lcd_clk = 1'b0;
  logic rst     = 1'b1;
  logic rst_s   = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always #5 lcd_clk = ~lcd_clk;

  lcd_timing_driver_if panel ();
  lcd_timing_driver_if panel_s ();

  lcd_timing_driver u_dut (
    .lcd_clk (lcd_clk),
    .sys_rst (rst),
    .lcd     (panel)
  );

  // Reduced timing: H 5/2/8/2 (17), V 3/2/4/2 (11), 187 cycles per frame.
  lcd_timing_driver #(
    .HSync (5), .HBack (2), .HDisp (8), .HFront (2),
    .VSync (3), .VBack (2), .VDisp (4), .VFront (2)
  ) u_dut_s (
    .lcd_clk (lcd_clk),
    .sys_rst (rst_s),
    .lcd     (panel_s)
  );

  // Renderer stand-in: one registered cycle of latency.
  always @(posedge lcd_clk) begin
    panel.pixel_data   <= {panel.pixel_xpos[7:0], panel.pixel_ypos[7:0], 8'hA5};
    panel_s.pixel_data <= {panel_s.pixel_xpos[7:0], panel_s.pixel_ypos[7:0], 8'hA5};
  end

  function automatic logic [23:0] exp_rgb(input int x, input int y);
`ifdef LCD_TEST_PATTERN_EN
    case (x / 60)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
`else
    return {8'(x), 8'(y), 8'hA5};
`endif
  endfunction

  task automatic tick();
    @(negedge lcd_clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    rst_s = 1'b1;
    repeat (5) @(negedge lcd_clk);
    checks++;
    if ({panel.lcd_hs, panel.lcd_vs, panel.lcd_de, panel.frame_start, panel.lcd_bl} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_ctrl: hs,vs,de,fs,bl got %b want 11000",
               {panel.lcd_hs, panel.lcd_vs, panel.lcd_de, panel.frame_start, panel.lcd_bl});
    end
    checks++;
    if ({panel.pixel_xpos, panel.pixel_ypos} !== 24'h0) begin
      errors++;
      $display("FAIL reset_pos: got %h want 000000", {panel.pixel_xpos, panel.pixel_ypos});
    end
    checks++;
    if (panel.lcd_rgb !== 24'h0) begin
      errors++;
      $display("FAIL reset_rgb: got %h want 000000", panel.lcd_rgb);
    end
    rst = 1'b0;
    tick();
    cyc = 0;
    checks++;
    if ({panel.frame_start, panel.lcd_hs, panel.lcd_vs, panel.lcd_de, panel.lcd_bl} !== 5'b10001) begin
      errors++;
      $display("FAIL release_ctrl: fs,hs,vs,de,bl got %b want 10001",
               {panel.frame_start, panel.lcd_hs, panel.lcd_vs, panel.lcd_de, panel.lcd_bl});
    end
  endtask

  // Lines 0..11: sync widths, no DE, no extra frame_start, backlight on.
  task automatic test_sync();
    int hs_low0, hs_low_all, hs_rise, vs_low, de_cnt, fs_cnt, bl_low;
    hs_low0 = 0; hs_low_all = 0; hs_rise = -1; vs_low = 0; de_cnt = 0; fs_cnt = 0; bl_low = 0;
    for (int c = 0; c < 12 * 525; c++) begin
      if (c > 0) tick();
      if (panel.lcd_hs === 1'b0) begin
        hs_low_all++;
        if (c < 525) hs_low0++;
      end else if (hs_rise < 0) begin
        hs_rise = c;
      end
      if (panel.lcd_vs === 1'b0) vs_low++;
      if (panel.lcd_de !== 1'b0) de_cnt++;
      if (c > 0 && panel.frame_start !== 1'b0) fs_cnt++;
      if (panel.lcd_bl !== 1'b1) bl_low++;
    end
    checks++;
    if (hs_low0 !== 41) begin errors++; $display("FAIL hs_width: got %0d want 41", hs_low0); end
    checks++;
    if (hs_rise !== 41) begin errors++; $display("FAIL hs_rise: got %0d want 41", hs_rise); end
    checks++;
    if (hs_low_all !== 492) begin
      errors++; $display("FAIL hs_per_line: got %0d want 492", hs_low_all);
    end
    checks++;
    if (vs_low !== 5250) begin errors++; $display("FAIL vs_width: got %0d want 5250", vs_low); end
    checks++;
    if (de_cnt !== 0) begin errors++; $display("FAIL de_blank: got %0d want 0", de_cnt); end
    checks++;
    if (fs_cnt !== 0) begin errors++; $display("FAIL fs_single: got %0d want 0", fs_cnt); end
    checks++;
    if (bl_low !== 0) begin errors++; $display("FAIL bl_on: got %0d want 0", bl_low); end
  endtask

  // First two active lines: DE run length, start column and panel data.
  task automatic test_de_data();
    int run, first, bad;
    logic [23:0] bad_got;
    for (int line = 12; line < 14; line++) begin
      run = 0; first = -1; bad = 0; bad_got = '0;
      for (int h = 0; h < 525; h++) begin
        tick();
        if (panel.lcd_de === 1'b1) begin
          run++;
          if (first < 0) first = h;
          if (panel.lcd_rgb !== exp_rgb(h - 43, line - 12)) begin bad++; bad_got = panel.lcd_rgb; end
        end else if (panel.lcd_rgb !== 24'h0) begin
          bad++; bad_got = panel.lcd_rgb;
        end
      end
      checks++;
      if (run !== 480) begin errors++; $display("FAIL de_run line %0d: got %0d want 480", line, run); end
      checks++;
      if (first !== 43) begin
        errors++; $display("FAIL de_first line %0d: got %0d want 43", line, first);
      end
      checks++;
      if (bad !== 0) begin
        errors++;
        $display("FAIL rgb_data line %0d: %0d bad pixels (last %h) want 0", line, bad, bad_got);
      end
    end
  endtask

  // Line 14 (row 2): request window edges relative to DE.
  task automatic test_req_edges();
    int req_cnt;
    req_cnt = 0;
    for (int h = 0; h < 525; h++) begin
      tick();
      if (panel.pixel_xpos !== 12'd0 || panel.pixel_ypos !== 12'd0) req_cnt++;
      if (h == 41) begin
        checks++;
        if ({panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de} !== {12'd0, 12'd0, 1'b0}) begin
          errors++; $display("FAIL req_before: x %0d y %0d de %b want 0 0 0",
                             panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de);
        end
      end
      if (h == 42) begin
        checks++;
        if ({panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de} !== {12'd0, 12'd2, 1'b0}) begin
          errors++; $display("FAIL req_first: x %0d y %0d de %b want 0 2 0",
                             panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de);
        end
      end
      if (h == 43) begin
        checks++;
        if ({panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de} !== {12'd1, 12'd2, 1'b1}) begin
          errors++; $display("FAIL req_second: x %0d y %0d de %b want 1 2 1",
                             panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de);
        end
      end
      if (h == 521) begin
        checks++;
        if ({panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de} !== {12'd479, 12'd2, 1'b1}) begin
          errors++; $display("FAIL req_last: x %0d y %0d de %b want 479 2 1",
                             panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de);
        end
      end
      if (h == 522) begin
        checks++;
        if ({panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de} !== {12'd0, 12'd0, 1'b1}) begin
          errors++; $display("FAIL req_after: x %0d y %0d de %b want 0 0 1",
                             panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de);
        end
      end
      if (h == 523) begin
        checks++;
        if (panel.lcd_de !== 1'b0) begin errors++; $display("FAIL de_fall: got %b want 0", panel.lcd_de); end
      end
    end
    checks++;
    if (req_cnt !== 480) begin errors++; $display("FAIL req_count: got %0d want 480", req_cnt); end
  endtask

  // One-cycle reset at line 100, pixel 200; frame restarts cleanly.
  task automatic test_mid_reset();
    int de_cnt, fs_cnt;
    while (cyc < 100 * 525 + 200) tick();
    checks++;
    if ({panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de} !== {12'd158, 12'd88, 1'b1}) begin
      errors++; $display("FAIL mid_pos: x %0d y %0d de %b want 158 88 1",
                         panel.pixel_xpos, panel.pixel_ypos, panel.lcd_de);
    end
    checks++;
    if (panel.lcd_rgb !== exp_rgb(157, 88)) begin
      errors++; $display("FAIL mid_rgb: got %h want %h", panel.lcd_rgb, exp_rgb(157, 88));
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({panel.lcd_hs, panel.lcd_vs, panel.lcd_de, panel.frame_start, panel.lcd_bl,
         panel.pixel_xpos, panel.pixel_ypos, panel.lcd_rgb} !== {5'b11000, 48'h0}) begin
      errors++;
      $display("FAIL mid_reset_vals: hs,vs,de,fs,bl %b x %0d y %0d rgb %h want 11000 0 0 0",
               {panel.lcd_hs, panel.lcd_vs, panel.lcd_de, panel.frame_start, panel.lcd_bl},
               panel.pixel_xpos, panel.pixel_ypos, panel.lcd_rgb);
    end
    rst = 1'b0;
    tick();
    cyc = 0;
    checks++;
    if ({panel.frame_start, panel.lcd_hs, panel.lcd_vs, panel.lcd_de, panel.lcd_bl} !== 5'b10001) begin
      errors++;
      $display("FAIL mid_release: fs,hs,vs,de,bl got %b want 10001",
               {panel.frame_start, panel.lcd_hs, panel.lcd_vs, panel.lcd_de, panel.lcd_bl});
    end
    de_cnt = 0; fs_cnt = 0;
    while (cyc < 12 * 525 + 43) begin
      tick();
      if (cyc < 12 * 525 + 43 && panel.lcd_de !== 1'b0) de_cnt++;
      if (panel.frame_start !== 1'b0) fs_cnt++;
    end
    checks++;
    if (de_cnt !== 0) begin errors++; $display("FAIL no_partial_de: got %0d want 0", de_cnt); end
    checks++;
    if (fs_cnt !== 0) begin errors++; $display("FAIL mid_fs_extra: got %0d want 0", fs_cnt); end
    checks++;
    if ({panel.lcd_de, panel.lcd_rgb} !== {1'b1, exp_rgb(0, 0)}) begin
      errors++; $display("FAIL restart_first_px: de %b rgb %h want 1 %h",
                         panel.lcd_de, panel.lcd_rgb, exp_rgb(0, 0));
    end
  endtask

  // Reduced instance: frame period, last pixel, no request until the next frame.
  task automatic test_frame_wrap();
    int fs1, fs2, de_cnt, last_de, first_de1, gap_req;
    logic [23:0] last_rgb, first_rgb1;
    fs1 = -1; fs2 = -1; de_cnt = 0; last_de = -1; first_de1 = -1; gap_req = 0;
    last_rgb = '0; first_rgb1 = '0;
    rst_s = 1'b0;
    tick();
    checks++;
    if (panel_s.frame_start !== 1'b1) begin
      errors++; $display("FAIL small_fs0: got %b want 1", panel_s.frame_start);
    end
    for (int k = 1; k <= 374; k++) begin
      tick();
      if (panel_s.frame_start === 1'b1) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (k < 187 && panel_s.lcd_de === 1'b1) begin
        de_cnt++; last_de = k; last_rgb = panel_s.lcd_rgb;
      end
      if (k >= 187 && first_de1 < 0 && panel_s.lcd_de === 1'b1) begin
        first_de1 = k; first_rgb1 = panel_s.lcd_rgb;
      end
      if (k > 150 && k < 279 && (panel_s.pixel_xpos !== 12'd0 || panel_s.pixel_ypos !== 12'd0))
        gap_req++;
    end
    checks++;
    if (fs1 !== 187) begin errors++; $display("FAIL frame_period: got %0d want 187", fs1); end
    checks++;
    if (fs2 !== 374) begin errors++; $display("FAIL frame_period2: got %0d want 374", fs2); end
    checks++;
    if (de_cnt !== 32) begin errors++; $display("FAIL small_de_cnt: got %0d want 32", de_cnt); end
    checks++;
    if (last_de !== 150) begin errors++; $display("FAIL last_de_pos: got %0d want 150", last_de); end
    checks++;
    if (last_rgb !== exp_rgb(7, 3)) begin
      errors++; $display("FAIL last_px_rgb: got %h want %h", last_rgb, exp_rgb(7, 3));
    end
    checks++;
    if (gap_req !== 0) begin errors++; $display("FAIL req_gap: got %0d want 0", gap_req); end
    checks++;
    if (first_de1 !== 279) begin
      errors++; $display("FAIL next_frame_de: got %0d want 279", first_de1);
    end
    checks++;
    if (first_rgb1 !== exp_rgb(0, 0)) begin
      errors++; $display("FAIL next_frame_rgb: got %h want %h", first_rgb1, exp_rgb(0, 0));
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_de_data();
    test_req_edges();
    test_mid_reset();
    test_frame_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
